// File: rtl/key_step_counter_pkg.sv
// Shared definitions for the key step counter: debounce FSM encoding, default width
// and a counter-sizing helper. The AUTO_REPEAT_EN macro is consumed in key_step_counter_debounce.
package key_step_counter_pkg;

  localparam int DEFAULT_WIDTH = 8;

  typedef enum logic [1:0] {
    ST_IDLE       = 2'd0,
    ST_DB_PRESS   = 2'd1,
    ST_PRESSED    = 2'd2,
    ST_DB_RELEASE = 2'd3
  } key_state_t;

  // Width of a counter that must hold values 0 .. n-1 (never narrower than 1 bit).
  function automatic int ctr_width(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/key_step_counter_debounce.sv
// Button front end: 2-flop synchronizer, press/release debounce FSM and, when
// AUTO_REPEAT_EN is defined, a hold-to-repeat timer. Emits one step strobe per accepted event.
module key_step_counter_debounce
  import key_step_counter_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 16,
  parameter int REPEAT_DELAY    = 64,
  parameter int REPEAT_RATE     = 16
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       key_in,
  output logic       step,
  output key_state_t state
);

  localparam int DW = ctr_width(DEBOUNCE_CYCLES);
  localparam logic [DW-1:0] DB_LAST = DW'(DEBOUNCE_CYCLES - 1);
  localparam logic [DW-1:0] DB_ONE  = DW'(1);

  if (DEBOUNCE_CYCLES < 1 || REPEAT_RATE < 1 || REPEAT_RATE > REPEAT_DELAY) begin : g_bad_params
    $error("key_step_counter_debounce: invalid debounce/repeat parameters");
  end

  logic          sync_q1;
  logic          sync_q2;
  key_state_t    state_q;
  key_state_t    state_d;
  logic [DW-1:0] db_cnt_q;
  logic [DW-1:0] db_cnt_d;
  logic          press_step;

  always_ff @(posedge clk) begin
    if (rst) begin
      sync_q1 <= 1'b0;
      sync_q2 <= 1'b0;
    end else begin
      sync_q1 <= key_in;
      sync_q2 <= sync_q1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= ST_IDLE;
      db_cnt_q <= '0;
    end else begin
      state_q  <= state_d;
      db_cnt_q <= db_cnt_d;
    end
  end

  // A level change is accepted only after the synchronized input has held the new
  // value on every edge of the debounce window; any glitch back restarts the wait.
  always_comb begin
    state_d    = state_q;
    db_cnt_d   = db_cnt_q;
    press_step = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (sync_q2) begin
          state_d  = ST_DB_PRESS;
          db_cnt_d = '0;
        end
      end
      ST_DB_PRESS: begin
        if (!sync_q2) begin
          state_d = ST_IDLE;
        end else if (db_cnt_q == DB_LAST) begin
          state_d    = ST_PRESSED;
          press_step = 1'b1;
        end else begin
          db_cnt_d = db_cnt_q + DB_ONE;
        end
      end
      ST_PRESSED: begin
        if (!sync_q2) begin
          state_d  = ST_DB_RELEASE;
          db_cnt_d = '0;
        end
      end
      ST_DB_RELEASE: begin
        if (sync_q2) begin
          state_d = ST_PRESSED;
        end else if (db_cnt_q == DB_LAST) begin
          state_d = ST_IDLE;
        end else begin
          db_cnt_d = db_cnt_q + DB_ONE;
        end
      end
      default: begin
        state_d  = ST_IDLE;
        db_cnt_d = '0;
      end
    endcase
  end

`ifdef AUTO_REPEAT_EN
  localparam int RW = ctr_width(REPEAT_DELAY);
  localparam logic [RW-1:0] REP_LAST   = RW'(REPEAT_DELAY - 1);
  localparam logic [RW-1:0] REP_RELOAD = RW'(REPEAT_DELAY - REPEAT_RATE);
  localparam logic [RW-1:0] REP_ONE    = RW'(1);

  logic [RW-1:0] rep_cnt_q;
  logic          rep_step;

  // Counts held cycles in PRESSED; after the first repeat it is reloaded so the
  // following repeats come every REPEAT_RATE cycles. Leaving PRESSED restarts it.
  always_ff @(posedge clk) begin
    if (rst) begin
      rep_cnt_q <= '0;
    end else if (state_q == ST_PRESSED && sync_q2) begin
      if (rep_cnt_q == REP_LAST) begin
        rep_cnt_q <= REP_RELOAD;
      end else begin
        rep_cnt_q <= rep_cnt_q + REP_ONE;
      end
    end else begin
      rep_cnt_q <= '0;
    end
  end

  assign rep_step = (state_q == ST_PRESSED) && sync_q2 && (rep_cnt_q == REP_LAST);
  assign step     = press_step | rep_step;
`else
  assign step     = press_step;
`endif

  assign state = state_q;

endmodule

// File: rtl/key_step_counter.sv
// Debounced push-button up/down counter feeding the LED display path, with switch presets.
// Define AUTO_REPEAT_EN to enable hold-to-repeat stepping.
module key_step_counter
  import key_step_counter_pkg::*;
#(
  parameter int WIDTH           = DEFAULT_WIDTH,
  parameter int DEBOUNCE_CYCLES = 16,
  parameter int REPEAT_DELAY    = 64,
  parameter int REPEAT_RATE     = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             key_in,
  input  logic             dir,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  output logic [WIDTH-1:0] cnt_data,
  output logic             key_pulse,
  output logic             wrap,
  output key_state_t       dbg_state
);

  localparam logic [WIDTH-1:0] CNT_ONE = WIDTH'(1);
  localparam logic [WIDTH-1:0] CNT_MAX = '1;

  logic             step;
  logic [WIDTH-1:0] cnt_next;
  logic             wrap_next;

  key_step_counter_debounce #(
    .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
    .REPEAT_DELAY    (REPEAT_DELAY),
    .REPEAT_RATE     (REPEAT_RATE)
  ) u_debounce (
    .clk    (clk),
    .rst    (rst),
    .key_in (key_in),
    .step   (step),
    .state  (dbg_state)
  );

  // A preset overrides a coincident step: the step is dropped and cannot wrap,
  // but key_pulse still reports that the button event happened.
  always_comb begin
    cnt_next  = cnt_data;
    wrap_next = 1'b0;
    if (load) begin
      cnt_next = load_val;
    end else if (step) begin
      if (dir) begin
        cnt_next  = cnt_data + CNT_ONE;
        wrap_next = (cnt_data == CNT_MAX);
      end else begin
        cnt_next  = cnt_data - CNT_ONE;
        wrap_next = (cnt_data == '0);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_data  <= '0;
      key_pulse <= 1'b0;
      wrap      <= 1'b0;
    end else begin
      cnt_data  <= cnt_next;
      key_pulse <= step;
      wrap      <= wrap_next;
    end
  end

endmodule

// File: tb/tb_key_step_counter.sv
// Bench for key_step_counter: directed button scenarios plus random key/dir/load traffic,
// checked every cycle against a window-based reference model (AUTO_REPEAT_EN aware).
`timescale 1ns/1ps
module tb_key_step_counter;
  import key_step_counter_pkg::*;

  localparam int W  = 8;
  localparam int DB = 4;
  localparam int RD = 8;
  localparam int RR = 4;

  logic         clk = 1'b0;
  logic         rst;
  logic         key_in;
  logic         dir;
  logic         load;
  logic [W-1:0] load_val;
  logic [W-1:0] cnt_data;
  logic         key_pulse;
  logic         wrap;
  key_state_t   dbg_state;

  key_step_counter #(
    .WIDTH           (W),
    .DEBOUNCE_CYCLES (DB),
    .REPEAT_DELAY    (RD),
    .REPEAT_RATE     (RR)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .key_in    (key_in),
    .dir       (dir),
    .load      (load),
    .load_val  (load_val),
    .cnt_data  (cnt_data),
    .key_pulse (key_pulse),
    .wrap      (wrap),
    .dbg_state (dbg_state)
  );

  // clock / reset
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // reference model: sync = key two samples late; a level change is accepted once the
  // last DB+1 synchronized samples all show the new level; repeats count edges held.
  int           edge_n = 0;
  bit           samp_q[$];
  bit           win_q[$];
  bit           m_level;
  bit           m_pressed;
  int           m_entry = 0;
  logic [W-1:0] m_cnt;
  bit           m_pulse;
  bit           m_wrap;
  int           pulse_edges[$];
  int           wrap_total = 0;

  always @(posedge clk) begin
    bit sync_now, all1, all0, step, pressed_now, rep;
    edge_n++;
    if (rst) begin
      samp_q    = {1'b0, 1'b0};
      win_q     = {};
      m_level   = 1'b0;
      m_pressed = 1'b0;
      m_cnt     = '0;
      m_pulse   = 1'b0;
      m_wrap    = 1'b0;
    end else begin
      sync_now = samp_q.pop_front();
      samp_q.push_back(key_in);
      win_q.push_back(sync_now);
      if (win_q.size() > DB + 1) void'(win_q.pop_front());
      all1 = (win_q.size() == DB + 1);
      all0 = all1;
      foreach (win_q[i]) begin
        if (!win_q[i]) all1 = 1'b0;
        if (win_q[i])  all0 = 1'b0;
      end
      step = 1'b0;
      if (!m_level && all1) begin
        m_level = 1'b1;
        step    = 1'b1;
      end else if (m_level && all0) begin
        m_level = 1'b0;
      end
      pressed_now = m_level && sync_now;
      rep = 1'b0;
`ifdef AUTO_REPEAT_EN
      if (m_pressed && pressed_now && (edge_n - m_entry) >= RD &&
          ((edge_n - m_entry - RD) % RR) == 0)
        rep = 1'b1;
`endif
      if (pressed_now && !m_pressed) m_entry = edge_n;
      m_pressed = pressed_now;
      step      = step | rep;
      m_pulse   = step;
      m_wrap    = 1'b0;
      if (load) begin
        m_cnt = load_val;
      end else if (step) begin
        if (dir) begin
          m_wrap = (m_cnt == '1);
          m_cnt  = m_cnt + 1'b1;
        end else begin
          m_wrap = (m_cnt == '0);
          m_cnt  = m_cnt - 1'b1;
        end
      end
    end
    #1;
    check_eq("cnt_data", 32'(cnt_data), 32'(m_cnt));
    check_eq("key_pulse", 32'(key_pulse), 32'(m_pulse));
    check_eq("wrap", 32'(wrap), 32'(m_wrap));
    if (key_pulse) pulse_edges.push_back(edge_n);
    if (wrap) wrap_total++;
  end

  // driver tasks (inputs change on the falling edge)
  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic do_reset(input int n);
    rst = 1'b1;
    tick(n);
    rst = 1'b0;
    check_eq("rst_cnt", 32'(cnt_data), 32'h0);
    check_eq("rst_pulse", 32'(key_pulse), 32'h0);
    check_eq("rst_wrap", 32'(wrap), 32'h0);
    check_eq("rst_state", 32'(dbg_state), 32'(ST_IDLE));
  endtask

  task automatic press(input bit d, input int hold, input int gap);
    dir    = d;
    key_in = 1'b1;
    tick(hold);
    key_in = 1'b0;
    tick(gap);
  endtask

  task automatic check_pulse(input string tag, input int base, input int idx, input int exp_off);
    int got;
    got = (idx < pulse_edges.size()) ? pulse_edges[idx] - base : -1;
    check_eq(tag, 32'(got), 32'(exp_off));
  endtask

  initial begin
    int t0, np, w0;
    int offs[$];
    rst = 1'b1; key_in = 1'b0; dir = 1'b1; load = 1'b0; load_val = '0;

    // 1: clean press, latency DB+3
    do_reset(3);
    t0 = edge_n; np = pulse_edges.size();
    press(1'b1, 20, 15);
    check_pulse("s1_latency", t0, np, 7);
`ifdef AUTO_REPEAT_EN
    check_eq("s1_cnt", 32'(cnt_data), 32'h03);
`else
    check_eq("s1_count", 32'(pulse_edges.size() - np), 32'd1);
    check_eq("s1_cnt", 32'(cnt_data), 32'h01);
`endif

    // 2: bouncing input never accepted
    do_reset(2);
    np = pulse_edges.size();
    repeat (5) begin
      key_in = 1'b1; tick(2);
      key_in = 1'b0; tick(2);
    end
    tick(10);
    check_eq("s2_pulses", 32'(pulse_edges.size() - np), 32'd0);
    check_eq("s2_cnt", 32'(cnt_data), 32'h00);

    // 3: preset FF, wrap up then wrap down
    do_reset(2);
    load_val = 8'hFF; load = 1'b1; tick(1); load = 1'b0;
    check_eq("s3_load", 32'(cnt_data), 32'hFF);
    w0 = wrap_total;
    press(1'b1, 10, 12);
    check_eq("s3_up_cnt", 32'(cnt_data), 32'h00);
    check_eq("s3_up_wrap", 32'(wrap_total - w0), 32'd1);
    press(1'b0, 10, 12);
    check_eq("s3_dn_cnt", 32'(cnt_data), 32'hFF);
    check_eq("s3_dn_wrap", 32'(wrap_total - w0), 32'd2);

    // 4: load coincident with the step (count at FF, dir up would wrap)
    w0 = wrap_total; t0 = edge_n; np = pulse_edges.size();
    dir = 1'b1; key_in = 1'b1;
    tick(6);
    load = 1'b1; load_val = 8'h5A;
    tick(1);
    load = 1'b0; load_val = '0;
    tick(4);
    key_in = 1'b0;
    tick(12);
    check_pulse("s4_pulse", t0, np, 7);
    check_eq("s4_cnt", 32'(cnt_data), 32'h5A);
    check_eq("s4_wrap", 32'(wrap_total - w0), 32'd0);

    // 5: reset in DB_PRESS with key held, full debounce afterwards
    do_reset(2);
    dir = 1'b1; key_in = 1'b1;
    tick(4);
    do_reset(2);
    t0 = edge_n; np = pulse_edges.size();
    tick(10);
    key_in = 1'b0;
    tick(12);
    check_pulse("s5_latency", t0, np, 7);
    check_eq("s5_count", 32'(pulse_edges.size() - np), 32'd1);
    check_eq("s5_cnt", 32'(cnt_data), 32'h01);

    // 6: long hold
    do_reset(2);
    t0 = edge_n; np = pulse_edges.size();
    press(1'b1, 30, 15);
`ifdef AUTO_REPEAT_EN
    offs = {7, 15, 19, 23, 27, 31};
`else
    offs = {7};
`endif
    check_eq("s6_count", 32'(pulse_edges.size() - np), 32'(offs.size()));
    foreach (offs[i]) check_pulse("s6_step", t0, np + i, offs[i]);

    // random traffic
    do_reset(2);
    repeat (90) begin
      key_in = 1'($urandom_range(0, 1));
      dir    = 1'($urandom_range(0, 1));
      repeat ($urandom_range(1, 12)) begin
        load     = ($urandom_range(0, 11) == 0);
        load_val = W'($urandom);
        rst      = ($urandom_range(0, 60) == 0);
        tick(1);
      end
      load = 1'b0;
      rst  = 1'b0;
    end
    key_in = 1'b0;
    tick(12);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
